// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding, register indices and bus widths
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int DATA_IDX = 0;
  localparam int DIR_IDX = 1;
  localparam int SCRATCH_IDX = 2;
  localparam int ADDR_W = 33;
  localparam int DATA_W = 32;
endpackage

// File: rtl/apb_protocol_gpio_apb_slave.sv
// gpio_apb_slave: zero-wait APB3 slave with DATA/DIR/SCRATCH registers driving tri-state pins
module gpio_apb_slave import apb_pkg::*; #(
  parameter int NUM_REGS = 3,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [GPIO_WIDTH-1:0] PWDATA,
  output logic [GPIO_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  inout  logic [GPIO_WIDTH-1:0] gpio_io
);
  logic [GPIO_WIDTH-1:0] data_r, dir_r, scratch_r;
  logic acc, err, wr;
  assign acc = PSEL && PENABLE;
  assign err = PADDR[32] || PADDR[31:0] >= 32'(NUM_REGS);
  assign wr = acc && PWRITE && !err;
  assign PREADY = 1'b1;
  assign PSLVERR = acc && err;
  assign PRDATA = (!acc || PWRITE || err) ? '0 :
                  PADDR[31:0] == 32'(DATA_IDX) ? gpio_io :
                  PADDR[31:0] == 32'(DIR_IDX) ? dir_r : scratch_r;
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      data_r <= '0;
      dir_r <= '0;
      scratch_r <= '0;
    end else if (wr) begin
      if (PADDR[31:0] == 32'(DATA_IDX)) data_r <= PWDATA;
      if (PADDR[31:0] == 32'(DIR_IDX)) dir_r <= PWDATA;
      if (PADDR[31:0] == 32'(SCRATCH_IDX)) scratch_r <= PWDATA;
    end
  end
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    assign gpio_io[i] = dir_r[i] ? data_r[i] : 1'bz;
  end
endmodule

// File: rtl/apb_protocol.sv
// apb_protocol: APB3 master FSM turning user requests into SETUP/ACCESS cycles on an internal GPIO slave
module apb_protocol import apb_pkg::*; #(
  parameter int NUM_REGS = 3,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_W-1:0]     apb_write_paddr,
  input  logic [ADDR_W-1:0]     apb_read_paddr,
  input  logic [DATA_W-1:0]     apb_write_data,
  output logic                  PSLVERR,
  output logic [ADDR_W-1:0]     apb_read_data_out,
  inout  logic [GPIO_WIDTH-1:0] gpio_io,
  output logic [DATA_W-1:0]     PWDATA
);
  state_t state, state_n;
  logic psel, penable, pwrite, pready;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] prdata;
  always_comb begin
    state_n = state == IDLE ? (transfer ? SETUP : IDLE) :
              state == SETUP ? ACCESS :
              !pready ? ACCESS : transfer ? SETUP : IDLE;
    psel = state != IDLE;
    penable = state == ACCESS;
  end
  // user inputs are captured only on entry to SETUP, so they may change freely during ACCESS
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state <= IDLE;
      pwrite <= 1'b0;
      paddr <= '0;
      PWDATA <= '0;
      apb_read_data_out <= '0;
    end else begin
      state <= state_n;
      if (state_n == SETUP) begin
        pwrite <= ~READ_WRITE;
        paddr <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
        if (!READ_WRITE) PWDATA <= apb_write_data;
      end
      if (penable && pready && !pwrite) apb_read_data_out <= {PSLVERR, prdata};
    end
  end
  gpio_apb_slave #(.NUM_REGS(NUM_REGS), .GPIO_WIDTH(GPIO_WIDTH)) u_slave (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .PSEL(psel),
    .PENABLE(penable),
    .PWRITE(pwrite),
    .PADDR(paddr),
    .PWDATA(PWDATA),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(PSLVERR),
    .gpio_io(gpio_io)
  );
endmodule

// File: tb/tb_apb_protocol.sv
// tb_apb_protocol: directed self-checking bench for the APB GPIO subsystem
module tb_apb_protocol;
  import apb_pkg::*;
  logic PCLK = 1'b0;
  logic PRESETn, transfer, READ_WRITE;
  logic [32:0] wa, ra;
  logic [31:0] wd;
  wire PSLVERR;
  wire [32:0] rdo;
  wire [31:0] gpio_io;
  wire [31:0] PWDATA;
  int n_cmp = 0;
  int n_err = 0;

  apb_protocol dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(wa), .apb_read_paddr(ra), .apb_write_data(wd),
    .PSLVERR(PSLVERR), .apb_read_data_out(rdo), .gpio_io(gpio_io), .PWDATA(PWDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // starts at a negedge in IDLE, returns at the negedge inside ACCESS; the unused address port carries an error address
  task start_xfer(input logic rw, input logic [32:0] a, input logic [31:0] d);
    transfer = 1'b1; READ_WRITE = rw; wd = d;
    wa = rw ? 33'h1_FFFFFFFF : a;
    ra = rw ? a : 33'h1_FFFFFFFF;
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
  endtask

  task end_xfer;
    @(negedge PCLK);
  endtask

  task test_reset;
    PRESETn = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0; wa = '0; ra = '0; wd = '0;
    repeat (2) @(negedge PCLK);
    n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
    n_cmp++; if (rdo !== 33'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdo); end
    n_cmp++; if (PWDATA !== 32'h0) begin n_err++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
    n_cmp++; if (dut.u_slave.dir_r !== 32'h0) begin n_err++; $display("FAIL reset_dir: got %h want 0", dut.u_slave.dir_r); end
    PRESETn = 1'b0;
  endtask

  task test_dir_zero;
    start_xfer(1'b0, 33'd1, 32'hFFFFFFFF);
    n_cmp++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL dir_pslverr: got %b want 0", PSLVERR); end
    n_cmp++; if (dut.penable !== 1'b1) begin n_err++; $display("FAIL dir_penable: got %b want 1", dut.penable); end
    end_xfer;
    start_xfer(1'b0, 33'd0, 32'h0);
    end_xfer;
    n_cmp++; if (gpio_io !== 32'h0) begin n_err++; $display("FAIL pins_zero: got %h want 00000000", gpio_io); end
    start_xfer(1'b1, 33'd0, 32'hDEADBEEF);
    end_xfer;
    n_cmp++; if (rdo !== 33'h0) begin n_err++; $display("FAIL read_data0: got %h want 0", rdo); end
  endtask

  task test_data9;
    transfer = 1'b1; READ_WRITE = 1'b0; wa = 33'd0; ra = 33'h1_FFFFFFFF; wd = 32'h9;
    @(negedge PCLK); transfer = 1'b0;
    n_cmp++; if (dut.state !== SETUP) begin n_err++; $display("FAIL d9_setup_state: got %0d want %0d", dut.state, SETUP); end
    n_cmp++; if (PWDATA !== 32'h9) begin n_err++; $display("FAIL d9_setup_pwdata: got %h want 9", PWDATA); end
    n_cmp++; if ({dut.psel, dut.penable} !== 2'b10) begin n_err++; $display("FAIL d9_setup_sel_en: got %b want 10", {dut.psel, dut.penable}); end
    @(negedge PCLK);
    n_cmp++; if (dut.state !== ACCESS) begin n_err++; $display("FAIL d9_access_state: got %0d want %0d", dut.state, ACCESS); end
    n_cmp++; if (PWDATA !== 32'h9) begin n_err++; $display("FAIL d9_access_pwdata: got %h want 9", PWDATA); end
    n_cmp++; if (gpio_io !== 32'h0) begin n_err++; $display("FAIL d9_early_pins: got %h want 00000000", gpio_io); end
    @(negedge PCLK);
    n_cmp++; if (gpio_io !== 32'h9) begin n_err++; $display("FAIL d9_pins: got %h want 00000009", gpio_io); end
    n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL d9_idle: got %0d want %0d", dut.state, IDLE); end
  endtask

  task test_scratch;
    start_xfer(1'b0, 33'd2, 32'd9);
    end_xfer;
    start_xfer(1'b1, 33'd2, 32'h0);
    n_cmp++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL scr_pslverr: got %b want 0", PSLVERR); end
    end_xfer;
    n_cmp++; if (rdo !== 33'h0_00000009) begin n_err++; $display("FAIL scr_read: got %h want 000000009", rdo); end
    start_xfer(1'b1, 33'd1, 32'h0);
    end_xfer;
    n_cmp++; if (rdo !== 33'h0_FFFFFFFF) begin n_err++; $display("FAIL dir_read: got %h want 0ffffffff", rdo); end
  endtask

  task test_error;
    start_xfer(1'b0, 33'd5, 32'hDEADBEEF);
    n_cmp++; if (PSLVERR !== 1'b1) begin n_err++; $display("FAIL err5_access: got %b want 1", PSLVERR); end
    end_xfer;
    n_cmp++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL err5_idle: got %b want 0", PSLVERR); end
    start_xfer(1'b0, 33'h1_00000000, 32'h000000FF);
    n_cmp++; if (PSLVERR !== 1'b1) begin n_err++; $display("FAIL errsel_access: got %b want 1", PSLVERR); end
    end_xfer;
    n_cmp++; if (gpio_io !== 32'h9) begin n_err++; $display("FAIL errsel_no_write: got %h want 00000009", gpio_io); end
    start_xfer(1'b1, 33'd5, 32'h0);
    end_xfer;
    n_cmp++; if (rdo !== 33'h1_00000000) begin n_err++; $display("FAIL err5_read: got %h want 100000000", rdo); end
    start_xfer(1'b1, 33'd2, 32'h0);
    end_xfer;
    n_cmp++; if (rdo !== 33'h0_00000009) begin n_err++; $display("FAIL scr_intact: got %h want 000000009", rdo); end
    start_xfer(1'b1, 33'h1_00000002, 32'h0);
    end_xfer;
    n_cmp++; if (rdo !== 33'h1_00000000) begin n_err++; $display("FAIL errsel_read: got %h want 100000000", rdo); end
  endtask

  task test_back_to_back;
    transfer = 1'b1; READ_WRITE = 1'b0; wa = 33'd1; ra = 33'h1_FFFFFFFF; wd = 32'hFFFFFFFF;
    @(negedge PCLK);
    n_cmp++; if (dut.state !== SETUP) begin n_err++; $display("FAIL b2b_s1: got %0d want %0d", dut.state, SETUP); end
    @(negedge PCLK);
    n_cmp++; if (dut.state !== ACCESS) begin n_err++; $display("FAIL b2b_a1: got %0d want %0d", dut.state, ACCESS); end
    wa = 33'd0; wd = 32'h55;
    #1;
    n_cmp++; if (PWDATA !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_hold: got %h want ffffffff", PWDATA); end
    @(negedge PCLK);
    n_cmp++; if (dut.state !== SETUP) begin n_err++; $display("FAIL b2b_s2: got %0d want %0d", dut.state, SETUP); end
    n_cmp++; if (PWDATA !== 32'h55) begin n_err++; $display("FAIL b2b_pwdata2: got %h want 55", PWDATA); end
    @(negedge PCLK);
    n_cmp++; if (dut.state !== ACCESS) begin n_err++; $display("FAIL b2b_a2: got %0d want %0d", dut.state, ACCESS); end
    wd = 32'hAA;
    @(negedge PCLK);
    n_cmp++; if (dut.state !== SETUP) begin n_err++; $display("FAIL b2b_s3: got %0d want %0d", dut.state, SETUP); end
    n_cmp++; if (gpio_io !== 32'h55) begin n_err++; $display("FAIL b2b_pins55: got %h want 00000055", gpio_io); end
    @(negedge PCLK);
    n_cmp++; if (dut.state !== ACCESS) begin n_err++; $display("FAIL b2b_a3: got %0d want %0d", dut.state, ACCESS); end
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL b2b_abort_state: got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (dut.u_slave.data_r !== 32'h0) begin n_err++; $display("FAIL b2b_no_commit: got %h want 0", dut.u_slave.data_r); end
    n_cmp++; if (dut.u_slave.dir_r !== 32'h0) begin n_err++; $display("FAIL b2b_pins_z: got dir %h want 0", dut.u_slave.dir_r); end
    n_cmp++; if (PWDATA !== 32'h0) begin n_err++; $display("FAIL b2b_pwdata_rst: got %h want 0", PWDATA); end
    PRESETn = 1'b0; transfer = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    test_reset;
    test_dir_zero;
    test_data9;
    test_scratch;
    test_error;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
